// File: rtl/cv_accel_pkg.sv
// Constants and encodings shared by the convolution weights loader and weights handler.
package cv_accel_pkg;

  localparam int unsigned WEIGHT_ROW_W         = 512;
  localparam int unsigned WB_ADR_W             = 11;
  localparam int unsigned WEIGHTS_IN_ROW_MODE0 = 64;
  localparam int unsigned WEIGHTS_IN_ROW_MODE1 = 128;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StLoad  = 2'd1,
    StFlush = 2'd2,
    StDone  = 2'd3
  } loader_state_e;

endpackage

// File: rtl/cv_beat_packer.sv
// Packs consecutive stream beats into one buffer row; row_valid marks the beat completing a row.
module cv_beat_packer
  import cv_accel_pkg::*;
#(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ROW_W  = WEIGHT_ROW_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              beat_valid,
  input  logic [DATA_W-1:0] beat_data,
  output logic              row_valid,
  output logic [ROW_W-1:0]  row_data
);

  localparam int unsigned BEATS = ROW_W / DATA_W;
  localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [ROW_W-1:0] pack_q, pack_d;
  logic             last_beat;

  assign last_beat = (beat_cnt_q == CNT_W'(BEATS - 1));

  always_comb begin
    pack_d     = pack_q;
    beat_cnt_d = beat_cnt_q;
    if (clear) begin
      beat_cnt_d = '0;
    end else if (beat_valid) begin
      for (int unsigned k = 0; k < BEATS; k++) begin
        if (beat_cnt_q == CNT_W'(k)) begin
          pack_d[k*DATA_W +: DATA_W] = beat_data;
        end
      end
      beat_cnt_d = last_beat ? '0 : beat_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      beat_cnt_q <= '0;
      pack_q     <= '0;
    end else begin
      beat_cnt_q <= beat_cnt_d;
      pack_q     <= pack_d;
    end
  end

  // The completing beat bypasses the pack register so the row is ready on the same edge.
  always_comb begin
    row_valid                              = beat_valid && last_beat;
    row_data                               = pack_q;
    row_data[ROW_W-DATA_W +: DATA_W]       = beat_data;
  end

endmodule

// File: rtl/cv_weights_loader.sv
// Streams 64-bit weight beats into the weights buffer, one packed row per consecutive address.
module cv_weights_loader
  import cv_accel_pkg::*;
#(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ROW_W  = WEIGHT_ROW_W,
  parameter int unsigned ADR_W  = WB_ADR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADR_W-1:0]  start_adr,
  input  logic [ADR_W:0]    num_rows,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              wb_we,
  output logic [ADR_W-1:0]  wb_addr,
  output logic [ROW_W-1:0]  wb_din,
  output logic              busy,
  output logic              done
);

  loader_state_e    state_q, state_d;
  logic [ADR_W:0]   rows_left_q, rows_left_d;
  logic [ADR_W-1:0] row_adr_q, row_adr_d;
  logic             wb_we_q, wb_we_d;
  logic [ADR_W-1:0] wb_addr_q, wb_addr_d;
  logic [ROW_W-1:0] wb_din_q, wb_din_d;

  logic             start_ok;
  logic             transfer;
  logic             row_valid;
  logic [ROW_W-1:0] row_data;

  assign start_ok = (state_q == StIdle) && start;
  assign transfer = s_valid && s_ready;

  cv_beat_packer #(
    .DATA_W (DATA_W),
    .ROW_W  (ROW_W)
  ) u_packer (
    .clk        (clk),
    .reset      (reset),
    .clear      (start_ok),
    .beat_valid (transfer),
    .beat_data  (s_data),
    .row_valid  (row_valid),
    .row_data   (row_data)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = (num_rows == '0) ? StDone : StLoad;
        end
      end
      StLoad: begin
        if (row_valid && (rows_left_q == {{ADR_W{1'b0}}, 1'b1})) begin
          state_d = StFlush;
        end
      end
      StFlush: state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    s_ready = (state_q == StLoad);
    busy    = (state_q != StIdle);
    done    = (state_q == StDone);
  end

  // Row address and remaining count advance once per completed row; address wraps naturally.
  always_comb begin
    rows_left_d = rows_left_q;
    row_adr_d   = row_adr_q;
    wb_we_d     = row_valid;
    wb_addr_d   = wb_addr_q;
    wb_din_d    = wb_din_q;
    if (start_ok) begin
      rows_left_d = num_rows;
      row_adr_d   = start_adr;
    end else if (row_valid) begin
      rows_left_d = rows_left_q - {{ADR_W{1'b0}}, 1'b1};
      row_adr_d   = row_adr_q + ADR_W'(1);
      wb_addr_d   = row_adr_q;
      wb_din_d    = row_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rows_left_q <= '0;
      row_adr_q   <= '0;
      wb_we_q     <= 1'b0;
      wb_addr_q   <= '0;
      wb_din_q    <= '0;
    end else begin
      rows_left_q <= rows_left_d;
      row_adr_q   <= row_adr_d;
      wb_we_q     <= wb_we_d;
      wb_addr_q   <= wb_addr_d;
      wb_din_q    <= wb_din_d;
    end
  end

  assign wb_we   = wb_we_q;
  assign wb_addr = wb_addr_q;
  assign wb_din  = wb_din_q;

endmodule

// File: tb/tb_cv_weights_loader.sv
// Scoreboard bench for cv_weights_loader: expected rows queued as beats go in, checked on wb_we.
module tb_cv_weights_loader;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned ROW_W  = 512;
  localparam int unsigned ADR_W  = 11;

  typedef struct packed {
    logic [ADR_W-1:0] addr;
    logic [ROW_W-1:0] data;
  } wr_t;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [ADR_W-1:0]  start_adr;
  logic [ADR_W:0]    num_rows;
  logic [DATA_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;
  logic              wb_we;
  logic [ADR_W-1:0]  wb_addr;
  logic [ROW_W-1:0]  wb_din;
  logic              busy;
  logic              done;

  int  n_checks = 0;
  int  n_fail   = 0;
  int  writes_seen = 0;
  wr_t exp_q[$];

  cv_weights_loader u_dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .start_adr (start_adr),
    .num_rows  (num_rows),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .wb_we     (wb_we),
    .wb_addr   (wb_addr),
    .wb_din    (wb_din),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [ROW_W-1:0] got,
                          input logic [ROW_W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] beat_val(input int tag, input int row, input int beat);
    return {16'hA5C3, 16'(tag), 16'(row), 16'(beat)};
  endfunction

  // Write monitor: every wb_we pulse must match the oldest queued row.
  always @(negedge clk) begin
    if (reset && wb_we) begin
      wr_t e;
      writes_seen++;
      if (exp_q.size() == 0) begin
        check_eq("spurious_we", ROW_W'(wb_we), '0);
      end else begin
        e = exp_q.pop_front();
        check_eq("wb_addr", ROW_W'(wb_addr), ROW_W'(e.addr));
        check_eq("wb_din", wb_din, e.data);
      end
    end
  end

  // Called at a negedge; returns at the negedge following the edge that accepted the beat.
  task automatic send_beat(input logic [DATA_W-1:0] d, input int gap, input bit poke,
                           input bit push_it, input wr_t e, output bit ok);
    int budget;
    ok     = 1'b0;
    budget = 200;
    while (!ok && budget > 0) begin
      start     = poke;
      start_adr = 11'h7F0;
      num_rows  = 12'd1;
      s_data    = d;
      s_valid   = ($urandom_range(99) >= gap);
      if (s_valid && s_ready) begin
        ok = 1'b1;
        if (push_it) exp_q.push_back(e);
      end
      @(negedge clk);
      budget--;
    end
    start   = 1'b0;
    s_valid = 1'b0;
    if (!ok) check_eq("beat_timeout", ROW_W'(s_ready), ROW_W'(1));
  endtask

  task automatic run_load(input logic [ADR_W-1:0] adr, input int rows, input int gap,
                          input int tag, input bit poke);
    int  w0, cyc;
    bit  ok;
    wr_t e;
    w0 = writes_seen;
    @(negedge clk);
    start = 1'b1; start_adr = adr; num_rows = (ADR_W+1)'(rows);
    @(negedge clk);
    start = 1'b0;
    check_eq("busy_after_start", ROW_W'(busy), ROW_W'(1));
    check_eq("ready_after_start", ROW_W'(s_ready), ROW_W'(rows != 0));
    check_eq("done_after_start", ROW_W'(done), ROW_W'(rows == 0));
    if (rows == 0) begin
      @(negedge clk);
      check_eq("zero_busy_clear", ROW_W'(busy), '0);
      check_eq("zero_done_clear", ROW_W'(done), '0);
      check_eq("zero_no_write", ROW_W'(writes_seen - w0), '0);
      return;
    end
    cyc = 0;
    for (int r = 0; r < rows; r++) begin
      e.addr = adr + ADR_W'(r);
      for (int b = 0; b < 8; b++) begin
        e.data[b*DATA_W +: DATA_W] = beat_val(tag, r, b);
        send_beat(beat_val(tag, r, b), gap, poke && (r == 0) && (b < 4), b == 7, e, ok);
        if (!ok) return;
        cyc++;
      end
    end
    // Now in the FLUSH cycle after the final transfer.
    check_eq("flush_we", ROW_W'(wb_we), ROW_W'(1));
    check_eq("flush_ready", ROW_W'(s_ready), '0);
    check_eq("flush_done", ROW_W'(done), '0);
    @(negedge clk);
    check_eq("done_pulse", ROW_W'(done), ROW_W'(1));
    check_eq("done_busy", ROW_W'(busy), ROW_W'(1));
    check_eq("done_we", ROW_W'(wb_we), '0);
    @(negedge clk);
    check_eq("done_clear", ROW_W'(done), '0);
    check_eq("idle_busy", ROW_W'(busy), '0);
    check_eq("write_count", ROW_W'(writes_seen - w0), ROW_W'(rows));
    check_eq("queue_empty", ROW_W'(exp_q.size()), '0);
    if (gap == 0) check_eq("stream_cycles", ROW_W'(cyc), ROW_W'(rows * 8));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int  w0;
    bit  ok;
    wr_t e;
    reset = 1'b0; start = 1'b0; start_adr = '0; num_rows = '0; s_data = '0; s_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_s_ready", ROW_W'(s_ready), '0);
    check_eq("rst_wb_we", ROW_W'(wb_we), '0);
    check_eq("rst_wb_addr", ROW_W'(wb_addr), '0);
    check_eq("rst_wb_din", wb_din, '0);
    check_eq("rst_busy", ROW_W'(busy), '0);
    check_eq("rst_done", ROW_W'(done), '0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    run_load(11'h010, 1, 0, 1, 1'b0);   // single row
    run_load(11'h100, 4, 0, 2, 1'b0);   // streaming
    run_load(11'h200, 3, 30, 3, 1'b0);  // random gaps
    run_load(11'd2046, 3, 0, 4, 1'b0);  // address wrap
    run_load(11'h055, 0, 0, 5, 1'b0);   // zero rows
    run_load(11'h300, 2, 0, 6, 1'b1);   // start during load ignored

    // Reset after 5 beats of row 1: row 0 is written, the partial row never is.
    w0 = writes_seen;
    @(negedge clk);
    start = 1'b1; start_adr = 11'h020; num_rows = 12'd2;
    @(negedge clk);
    start = 1'b0;
    e.addr = 11'h020;
    for (int k = 0; k < 13; k++) begin
      if (k < 8) e.data[k*DATA_W +: DATA_W] = beat_val(7, 0, k);
      send_beat(beat_val(7, k / 8, k % 8), 0, 1'b0, k == 7, e, ok);
    end
    #2 reset = 1'b0;
    #1;
    check_eq("async_s_ready", ROW_W'(s_ready), '0);
    check_eq("async_wb_we", ROW_W'(wb_we), '0);
    check_eq("async_wb_addr", ROW_W'(wb_addr), '0);
    check_eq("async_wb_din", wb_din, '0);
    check_eq("async_busy", ROW_W'(busy), '0);
    check_eq("async_done", ROW_W'(done), '0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("reset_writes", ROW_W'(writes_seen - w0), ROW_W'(1));
    check_eq("reset_queue", ROW_W'(exp_q.size()), '0);

    run_load(11'h030, 1, 0, 8, 1'b0);   // fresh load starts at beat 0

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cv_weights_loader.md
# cv_weights_loader

Fills the on-chip weights buffer read by the convolution weights handler. Accepts 64-bit weight beats over a valid/ready stream, packs 8 consecutive beats into one 512-bit buffer row, and writes the rows to consecutive buffer addresses starting at a programmed base. One load command writes `num_rows` rows. `busy` lets the layer controller keep the feature-map read phase (`re_fm_en`) idle while a load is in progress.

## Interface
- `DATA_W`, 64, stream beat width in bits
- `ROW_W`, 512, buffer row width; equals 64 mode-0 8-bit weights or 4 × 128 mode-1 weights
- `ADR_W`, 11, buffer address width
- `BEATS`, `ROW_W/DATA_W` (8), beats per row; derived, not overridden

- `clk`  in  1  single clock; all state updates on the rising edge
- `reset`  in  1  asynchronous, active-low (0 = reset)
- `start`  in  1  load command; sampled only in IDLE
- `start_adr`  in  ADR_W  first buffer address; latched on accepted `start`
- `num_rows`  in  ADR_W+1  rows to write, 0..2048; latched on accepted `start`
- `s_data`  in  DATA_W  weight beat; beat k of a row goes to row bits [k*64 +: 64]
- `s_valid`  in  1  beat valid
- `s_ready`  out  1  beat accept; a transfer occurs when `s_valid && s_ready`
- `wb_we`  out  1  buffer write enable
- `wb_addr`  out  ADR_W  buffer write address
- `wb_din`  out  ROW_W  buffer write data
- `busy`  out  1  load in progress
- `done`  out  1  one-cycle completion pulse

## Operation
- States: IDLE, LOAD, FLUSH, DONE.
- IDLE: `s_ready`=0, `busy`=0. On `start`: latch `start_adr` and `num_rows`, clear the beat counter. If `num_rows`≠0, go to LOAD; otherwise go to DONE with no writes.
- LOAD: `s_ready`=1. Each transfer stores `s_data` in the pack register slot selected by the beat counter, then increments the counter modulo BEATS.
- On the 8th transfer of a row:
  - the full row (with the current beat in slot 7) is copied into the `wb_din` register;
  - `wb_we` is set for the next cycle, and `wb_addr` takes the row address;
  - the row counter decrements.
- The pack register is independent of `wb_din`. Beat 0 of the next row may transfer in the same cycle that `wb_we` is high, so throughput is 1 beat/cycle and no bubbles are required.
- When the last beat of the last row transfers, go to FLUSH. In FLUSH, `s_ready`=0 and `wb_we`=1 for the final row.
- FLUSH → DONE. In DONE, `done`=1 for exactly one cycle, then return to IDLE.
- Row address: `start_adr + row_index`, computed modulo 2^ADR_W. The address wraps from 2047 to 0.
- `start` while busy is ignored; it is not queued.
- `s_valid` low stalls the load indefinitely. State, counters and `wb_we`=0 hold during the stall.
- `s_data` is ignored whenever `s_ready`=0.
- Reset asserted mid-load:
  - FSM returns to IDLE immediately; counters and the pack register clear;
  - the partial row is discarded and no write is issued.
- Reset values: `s_ready`=0, `wb_we`=0, `wb_addr`=0, `wb_din`=0, `busy`=0, `done`=0.

## Timing
- Accepted `start` at edge T0 → LOAD from T0; `s_ready`=1 in the cycle after T0.
- Write latency: the 8th beat of a row transfers at edge E → `wb_we`=1 with that row's data and address in cycle E..E+1, for exactly one cycle per row.
- With `s_valid` held high: N rows take 8N transfer cycles, then 1 FLUSH cycle (final write), then 1 DONE cycle.
- `busy`=1 from the cycle after the accepted `start` through the DONE cycle inclusive.
- `done` rises one cycle after the final `wb_we`.
- `num_rows`=0: `busy` and `done` are both 1 in the single cycle after `start`, with no `wb_we`.
- All outputs are registered or decoded from state only; there are no combinational paths from `s_valid`/`s_data` to outputs.

## Structure
- Shared package `cv_accel_pkg` holds `WEIGHT_ROW_W`=512, `WB_ADR_W`=11, `WEIGHTS_IN_ROW_MODE0`=64, `WEIGHTS_IN_ROW_MODE1`=128, and the loader state encoding. The weights handler uses the same constants.
- One sub-module: `cv_beat_packer`. It contains the beat counter and pack register, and emits `row_valid` with the 512-bit row. The FSM, address and row counters stay in the top level.

## Test plan
- Single row, `start_adr`=0x010, `num_rows`=1, beats 0x0..0x7 back-to-back → one `wb_we` at address 0x010 with `wb_din[k*64 +: 64]`=k; `done` 2 cycles after the 8th beat.
- Streaming, `num_rows`=4, `s_valid` always high → `s_ready` continuous for 32 cycles; writes at `start_adr`+0..3 every 8 cycles; no dropped beats.
- Random `s_valid` gaps (30 % low), `num_rows`=3 → same data and addresses as the gap-free run; `wb_we` only after each 8th transfer.
- Wrap: `start_adr`=2046, `num_rows`=3 → writes at 2046, 2047, 0.
- `num_rows`=0 → `busy`/`done` pulse once, no `wb_we`. A `start` issued during a load → ignored, with row count unchanged.
- Reset low after 5 beats of row 1 → outputs return to reset values asynchronously; no write occurs. A new load after reset starts from beat 0.
